reservation_station: RTL
========================

Name: reservation_station

Overview:
Single-entry reservation station. It accepts one dispatched instruction from the dispatch router (one-hot route bit, tag/value operand pairs, destination ROB tag). It snoops the common data bus (CDB) for outstanding operand tags, then issues to its functional unit through a valid/ready handshake. One instance per route bit; `busy` feeds the router's `*_rs_busy` vector.

Parameters:
XLEN, 32, operand/data width
ROB_TAG_WIDTH, 6, width of ROB tags
CTRL_WIDTH, 10, opaque control bundle width (funct3/funct7/op select), passed through untouched

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
route  input  1  dispatch strobe for this entry (router output bit)
ctrl_in  input  CTRL_WIDTH  control bundle of dispatched instruction
dest_tag_in  input  ROB_TAG_WIDTH  ROB tag the result is written to
q1_valid  input  1  operand 1 still pending on tag q1
q1  input  ROB_TAG_WIDTH  operand 1 tag
v1  input  XLEN  operand 1 value (used when q1_valid=0)
q2_valid  input  1  operand 2 still pending on tag q2
q2  input  ROB_TAG_WIDTH  operand 2 tag
v2  input  XLEN  operand 2 value (used when q2_valid=0)
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  ROB_TAG_WIDTH  CDB broadcast tag
cdb_data  input  XLEN  CDB broadcast value
flush  input  1  pipeline flush (mispredict/exception)
fu_ready  input  1  functional unit accepts an issue this cycle
busy  output  1  entry occupied
fu_valid  output  1  issue request; operands complete
fu_ctrl  output  CTRL_WIDTH  stored control bundle
fu_op1  output  XLEN  operand 1 value
fu_op2  output  XLEN  operand 2 value
fu_dest_tag  output  ROB_TAG_WIDTH  stored destination tag

Behaviour:
- Reset (async, reset_n=0): state EMPTY; busy=0, fu_valid=0. All stored ctrl/tag/value registers and all data outputs are 0.
- States: EMPTY, WAIT (≥1 operand pending), READY (fu_valid=1). busy=1 in WAIT and READY. All outputs are registered or decoded from state only.
- Dispatch (EMPTY, route=1): latch ctrl_in, dest_tag_in, q1/v1/q1_valid, q2/v2/q2_valid.
  - Same-cycle capture: if qN_valid and cdb_valid and cdb_tag==qN, store cdb_data as the value and clear the pending flag.
  - Next state is READY if no operand is pending after capture, otherwise WAIT.
  - Minimum dispatch→fu_valid latency is 1 cycle.
- route=1 while busy=1 is a protocol violation. It is ignored, the entry is unchanged, and the bench asserts on it.
- WAIT: each cycle, for each pending operand N, if cdb_valid and cdb_tag==stored qN, capture cdb_data and clear the pending flag.
  - Both operands may capture from one broadcast (same tag).
  - Transition to READY the cycle after the last pending flag clears.
  - Non-matching broadcasts are ignored.
- READY: fu_valid=1 and operands/ctrl/dest are held stable until fu_ready=1. On a handshake (fu_valid & fu_ready at the edge), the next state is EMPTY.
  - busy is still 1 during the handshake cycle, so a new dispatch is possible from the following cycle (one-cycle bubble per entry).
- Stored tags are not compared after capture; stale CDB matches in READY have no effect.
- flush=1: synchronous clear to EMPTY from any state, and it has priority over dispatch, capture and handshake.
  - A handshake in the flush cycle is still seen by the FU. The FU/ROB discard it; the entry must not re-issue.
- Reset asserted mid-operation: immediate return to reset values regardless of clock.
- Values of unused fields in EMPTY are don't-care for the design, but must be 0 after reset.

Test Plan:
- Dispatch ready operands: route=1, q1_valid=q2_valid=0, v1=5, v2=7, dest=3 → next cycle fu_valid=1, op1=5, op2=7, dest_tag=3. With fu_ready=1 → busy=0 the following cycle.
- Tag wakeup: dispatch q1_valid=1, q1=12, v2=9. Two cycles later cdb_valid=1, tag=12, data=0xDEADBEEF → fu_valid=1 the next cycle with op1=0xDEADBEEF. A CDB tag=11 beforehand produces no change.
- Same-cycle capture: dispatch q1=q2=20 (both pending) with CDB tag=20, data=42 in the same cycle → READY next cycle, op1=op2=42.
- Backpressure: READY with fu_ready=0 for 4 cycles → fu_valid and all outputs stable. fu_ready=1 → EMPTY next cycle. Dispatch during the handshake cycle is rejected, and dispatch the next cycle is accepted.
- Flush: flush=1 in WAIT, then in READY, then coincident with route=1 → each time busy=0 and fu_valid=0 next cycle, and no entry is captured.
- Async reset: assert reset_n=0 mid-cycle in READY → busy/fu_valid drop to 0 before the next clock edge, and data outputs are 0.

Source files
------------

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_station
//  Description : Single-entry reservation station. It accepts one dispatched
//                instruction, snoops the CDB for pending operand tags, and
//                issues to its functional unit with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_station #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 6,
  parameter int CTRL_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     route,
  input  logic [CTRL_WIDTH-1:0]    ctrl_in,
  input  logic [ROB_TAG_WIDTH-1:0] dest_tag_in,
  input  logic                     q1_valid,
  input  logic [ROB_TAG_WIDTH-1:0] q1,
  input  logic [XLEN-1:0]          v1,
  input  logic                     q2_valid,
  input  logic [ROB_TAG_WIDTH-1:0] q2,
  input  logic [XLEN-1:0]          v2,
  input  logic                     cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  input  logic                     flush,
  input  logic                     fu_ready,
  output logic                     busy,
  output logic                     fu_valid,
  output logic [CTRL_WIDTH-1:0]    fu_ctrl,
  output logic [XLEN-1:0]          fu_op1,
  output logic [XLEN-1:0]          fu_op2,
  output logic [ROB_TAG_WIDTH-1:0] fu_dest_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CTRL_WIDTH-1:0]    ctrl_q, ctrl_d;
  logic [ROB_TAG_WIDTH-1:0] dest_q, dest_d;
  logic [ROB_TAG_WIDTH-1:0] q1_q, q1_d, q2_q, q2_d;
  logic                     p1_q, p1_d, p2_q, p2_d;
  logic [XLEN-1:0]          v1_q, v1_d, v2_q, v2_d;

  // Next-state logic: dispatch capture, CDB wakeup, issue handshake, flush.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    if (flush) begin
      // Flush wins over everything; the entry is simply abandoned.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (route) begin
            ctrl_d = ctrl_in;
            dest_d = dest_tag_in;
            q1_d   = q1;
            q2_d   = q2;
            p1_d   = q1_valid;
            p2_d   = q2_valid;
            v1_d   = v1;
            v2_d   = v2;
            // A broadcast in the dispatch cycle would otherwise be missed.
            if (q1_valid && cdb_valid && (cdb_tag == q1)) begin
              v1_d = cdb_data;
              p1_d = 1'b0;
            end
            if (q2_valid && cdb_valid && (cdb_tag == q2)) begin
              v2_d = cdb_data;
              p2_d = 1'b0;
            end
            state_d = (p1_d || p2_d) ? WAIT : READY;
          end
        end
        WAIT: begin
          if (p1_q && cdb_valid && (cdb_tag == q1_q)) begin
            v1_d = cdb_data;
            p1_d = 1'b0;
          end
          if (p2_q && cdb_valid && (cdb_tag == q2_q)) begin
            v2_d = cdb_data;
            p2_d = 1'b0;
          end
          state_d = (p1_d || p2_d) ? WAIT : READY;
        end
        READY: begin
          // Tags are no longer compared here; only the handshake matters.
          if (fu_ready) state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ctrl_q  <= '0;
      dest_q  <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      v1_q    <= '0;
      v2_q    <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  // Outputs come straight from registers or a decode of the state.
  always_comb begin
    busy        = (state_q != EMPTY);
    fu_valid    = (state_q == READY);
    fu_ctrl     = ctrl_q;
    fu_op1      = v1_q;
    fu_op2      = v2_q;
    fu_dest_tag = dest_q;
  end

endmodule
`default_nettype wire
